// File: rtl/task_14_pkg.sv
// Shared constants and state encoding for the task-14 input/output stage pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package task_14_pkg;

  // Depth of the input-stage FIFO; one output-stage packet never exceeds it.
  localparam int TASK14_FIFO_DEPTH = 32;

  // Word width carried between the two stages.
  localparam int TASK14_DATA_W = 8;

  // Output-stage packet life cycle.
  typedef enum logic [1:0] {
    s_IDLE    = 2'd0,
    s_COLLECT = 2'd1,
    s_DRAIN   = 2'd2,
    s_DONE    = 2'd3
  } task_output_enum;

endpackage : task_14_pkg

// File: rtl/task_14_out_buf.sv
// Packet buffer: DEPTH x DATA_WIDTH simple dual-port array, one write and one read port.
// Latency: write lands at the clock edge; read data follows the registered read address one edge later.
// Backpressure: none; the caller holds the read address to hold the data.
module task_14_out_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AW         = 5
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         raddr_q;

  // Storage has no reset: contents are only read after they have been written.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Registering the address lets the data appear on the same edge as the owner's valid flag.
  always_ff @(posedge i_clk) begin
    raddr_q <= i_raddr;
  end

  assign o_rdata = mem_q[raddr_q];

endmodule : task_14_out_buf

// File: rtl/task_14_out.sv
// Output stage: collects a word burst, replays it as an AXI-stream packet, then pulses o_output_last.
// Latency: 2 edges from the edge capturing the last burst word to the edge raising o_tvalid; no bubbles under i_tready=1.
// Backpressure: i_tready low holds o_tdata/o_tlast; optional checksum beat via TASK14_OUT_CHECKSUM_EN.
module task_14_out
  import task_14_pkg::*;
#(
  parameter int DATA_WIDTH = TASK14_DATA_W,
  parameter int DEPTH      = TASK14_FIFO_DEPTH,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_enb,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_output_last,
  output logic                  o_overflow,
  output logic                  o_err
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  task_output_enum       state_q;
  logic [CNT_W-1:0]      wr_cnt_q;
  logic [CNT_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      rd_ptr_d;
  logic [CNT_W-1:0]      last_idx;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  output_last_q;
  logic                  overflow_q;
  logic                  err_q;
  logic                  beat_done;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] beat_data;

  // A beat leaves only while draining with a valid word presented and the sink ready.
  assign beat_done = (state_q == s_DRAIN) && tvalid_q && i_tready;

  // Write port: the first word of a burst goes to address 0, later words append while room remains.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    if (i_rst_n && i_enb) begin
      if (state_q == s_IDLE) begin
        wr_en = 1'b1;
      end else if ((state_q == s_COLLECT) && (wr_cnt_q != DEPTH_C)) begin
        wr_en   = 1'b1;
        wr_addr = wr_cnt_q[AW-1:0];
      end
    end
  end

  // Read pointer: rewinds when the burst ends, steps on every accepted beat except the final one.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (!i_rst_n) begin
      rd_ptr_d = '0;
    end else if ((state_q == s_COLLECT) && !i_enb) begin
      rd_ptr_d = '0;
    end else if (beat_done && !tlast_q) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
    end
  end

  // The buffer registers rd_ptr_d, so its output always tracks rd_ptr_q.
  task_14_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (wr_addr),
    .i_wdata (i_data),
    .i_raddr (rd_ptr_d[AW-1:0]),
    .o_rdata (rd_data)
  );

`ifdef TASK14_OUT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  // Running XOR of every word actually stored; dropped overflow words do not contribute.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      csum_q <= '0;
    end else if (wr_en) begin
      csum_q <= (state_q == s_IDLE) ? i_data : (csum_q ^ i_data);
    end
  end

  // The checksum rides one extra beat after the data, and only that beat carries tlast.
  assign last_idx  = wr_cnt_q;
  assign beat_data = (rd_ptr_q == wr_cnt_q) ? csum_q : rd_data;
`else
  assign last_idx  = wr_cnt_q - ONE_C;
  assign beat_data = rd_data;
`endif

  // FSM with registered stream/status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= s_IDLE;
      wr_cnt_q      <= '0;
      rd_ptr_q      <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      output_last_q <= 1'b0;
      overflow_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      output_last_q <= 1'b0;
      case (state_q)
        s_IDLE: begin
          if (i_enb) begin
            state_q    <= s_COLLECT;
            wr_cnt_q   <= ONE_C;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        s_COLLECT: begin
          if (i_enb) begin
            if (wr_cnt_q == DEPTH_C) begin
              overflow_q <= 1'b1;
            end else begin
              wr_cnt_q <= wr_cnt_q + ONE_C;
            end
          end else begin
            state_q <= s_DRAIN;
          end
        end
        s_DRAIN: begin
          if (i_enb) begin
            err_q <= 1'b1;
          end
          if (beat_done && tlast_q) begin
            state_q       <= s_DONE;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            output_last_q <= 1'b1;
          end else begin
            // First DRAIN cycle primes the buffer read; valid rises on the following edge.
            tvalid_q <= 1'b1;
            tlast_q  <= (rd_ptr_d == last_idx);
          end
        end
        s_DONE: begin
          if (i_enb) begin
            err_q <= 1'b1;
          end
          state_q <= s_IDLE;
        end
        default: begin
          state_q <= s_IDLE;
        end
      endcase
    end
  end

  // Data is forced to zero whenever no beat is presented, so idle/reset output is clean.
  assign o_tdata       = tvalid_q ? beat_data : '0;
  assign o_tvalid      = tvalid_q;
  assign o_tlast       = tlast_q;
  assign o_output_last = output_last_q;
  assign o_overflow    = overflow_q;
  assign o_err         = err_q;

endmodule : task_14_out

// File: tb/tb_task_14_out.sv
// Bench for task_14_out: table-driven bursts, hand sequences for error/reset, then random bursts.
// Latency: n/a.
// Backpressure: sink ready driven per scenario (always, toggling, random, stalled).
module tb_task_14_out;
  import task_14_pkg::*;

  localparam int DEPTH = TASK14_FIFO_DEPTH;
`ifdef TASK14_OUT_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       enb = 1'b0;
  logic       tready = 1'b0;
  logic [7:0] o_tdata;
  logic       o_tvalid, o_tlast, o_output_last, o_overflow, o_err;

  always #5 clk = ~clk;

  task_14_out dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_data        (data),
    .i_enb         (enb),
    .o_tdata       (o_tdata),
    .o_tvalid      (o_tvalid),
    .i_tready      (tready),
    .o_tlast       (o_tlast),
    .o_output_last (o_output_last),
    .o_overflow    (o_overflow),
    .o_err         (o_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int  cyc = 0;
  int  beats_q[$];
  bit  last_q[$];
  int  ol_count = 0;
  int  last_hs_cyc = -10;
  int  last_cap_edge = 0;
  int  first_valid_cyc = -1;
  bit  ovf_at_last = 1'b0;
  bit  prev_valid = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;
  int  ready_mode = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (enb) last_cap_edge = cyc + 1;
      if (o_tvalid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && o_tvalid) begin
        chk("hold_tdata", o_tdata, prev_data);
        chk("hold_tlast", o_tlast, prev_last);
      end
      if (o_tvalid && tready) begin
        beats_q.push_back(o_tdata);
        last_q.push_back(o_tlast);
        if (o_tlast) begin
          last_hs_cyc = cyc;
          ovf_at_last = o_overflow;
        end
      end
      if (o_output_last) begin
        ol_count++;
        chk("output_last_timing", cyc, last_hs_cyc + 1);
      end
      prev_valid = o_tvalid;
      prev_stall = o_tvalid && !tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
    end else begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end
  end

  // Sink ready: 0 always, 1 toggling, 2 random, other stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        2:       tready = 1'($urandom_range(0, 1));
        default: tready = 1'b0;
      endcase
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic start_chk(input string tag);
    chk({tag, ":ovf_cleared"}, o_overflow, 0);
    chk({tag, ":err_cleared"}, o_err, 0);
  endtask

  task automatic drive_burst(input string tag, input int words[$]);
    for (int i = 0; i < words.size(); i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start_chk(tag);
      enb  = 1'b1;
      data = 8'(words[i]);
    end
    @(posedge clk);
    #1;
    if (words.size() == 1) start_chk(tag);
    enb = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int got);
    int w = 0;
    while (ol_count == got && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ":done_pulses"}, ol_count - got, 1);
  endtask

  task automatic wait_valid(input string tag);
    int w = 0;
    while (!o_tvalid && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ":valid_seen"}, o_tvalid, 1);
  endtask

  // Reference: the first DEPTH burst words in order, plus their XOR when the checksum beat is built in.
  task automatic check_data(input string tag, input int words[$]);
    int model[$];
    int cs = 0;
    int lp = -1;
    for (int i = 0; i < words.size() && i < DEPTH; i++) begin
      model.push_back(words[i] & 'hFF);
      cs ^= words[i] & 'hFF;
    end
    if (CS != 0) model.push_back(cs);
    for (int i = 0; i < model.size(); i++)
      chk($sformatf("%s:beat%0d", tag, i), (i < beats_q.size()) ? beats_q[i] : 'hDEAD, model[i]);
    for (int i = 0; i < last_q.size(); i++)
      if (last_q[i] && lp < 0) lp = i;
    chk({tag, ":tlast_pos"}, lp, model.size() - 1);
  endtask

  task automatic run_packet(input string tag, input int words[$], input int rmode,
                            input int exp_beats, input bit exp_ovf);
    int got;
    beats_q.delete();
    last_q.delete();
    first_valid_cyc = -1;
    ready_mode = rmode;
    got = ol_count;
    drive_burst(tag, words);
    wait_done(tag, got);
    chk({tag, ":beats"}, beats_q.size(), exp_beats + CS);
    check_data(tag, words);
    chk({tag, ":ovf"}, ovf_at_last, exp_ovf);
    if (rmode == 0) begin
      chk({tag, ":latency"}, first_valid_cyc - last_cap_edge, 2);
      chk({tag, ":no_bubble"}, last_hs_cyc - first_valid_cyc, exp_beats + CS - 1);
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int len;
    int base;
    int step;
    int rmode;
    int exp_beats;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[6];
  int   q[$];
  int   len;
  int   got;

  initial begin
    vecs[0] = '{5,  'h11, 1, 0, 5,  1'b0};
    vecs[1] = '{5,  'h11, 1, 1, 5,  1'b0};
    vecs[2] = '{34, 'h00, 1, 0, 32, 1'b1};
    vecs[3] = '{1,  'hA5, 0, 0, 1,  1'b0};
    vecs[4] = '{32, 'h40, 3, 2, 32, 1'b0};
    vecs[5] = '{33, 'h80, 7, 1, 32, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst:tvalid", o_tvalid, 0);
    chk("rst:tdata", o_tdata, 0);
    chk("rst:tlast", o_tlast, 0);
    chk("rst:output_last", o_output_last, 0);
    chk("rst:overflow", o_overflow, 0);
    chk("rst:err", o_err, 0);
    rst_n = 1'b1;

    // Table of bursts
    for (int v = 0; v < 6; v++) begin
      q.delete();
      for (int i = 0; i < vecs[v].len; i++) q.push_back((vecs[v].base + i * vecs[v].step) & 'hFF);
      run_packet($sformatf("vec%0d", v), q, vecs[v].rmode, vecs[v].exp_beats, vecs[v].exp_ovf);
    end

    // i_enb pulse while draining: sticky error, data untouched
    q = '{'h21, 'h22, 'h23, 'h24};
    beats_q.delete();
    last_q.delete();
    ready_mode = 3;
    got = ol_count;
    drive_burst("err", q);
    wait_valid("err");
    @(posedge clk);
    #1;
    enb  = 1'b1;
    data = 8'hEE;
    @(posedge clk);
    #1;
    enb = 1'b0;
    chk("err:sticky", o_err, 1);
    ready_mode = 0;
    wait_done("err", got);
    chk("err:beats", beats_q.size(), 4 + CS);
    check_data("err", q);
    chk("err:still_set", o_err, 1);

    // Next burst clears the error (start_chk inside)
    q = '{'h31, 'h32};
    run_packet("after_err", q, 0, 2, 1'b0);

    // Reset pulse mid-drain: packet aborted, no done pulse
    q = '{'h51, 'h52, 'h53, 'h54, 'h55};
    ready_mode = 3;
    drive_burst("rstmid", q);
    wait_valid("rstmid");
    got = ol_count;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rstmid:tvalid", o_tvalid, 0);
    chk("rstmid:tlast", o_tlast, 0);
    ready_mode = 0;
    repeat (10) @(negedge clk);
    chk("rstmid:no_done", ol_count - got, 0);
    q = '{'h61, 'h62, 'h63};
    run_packet("post_rst", q, 0, 3, 1'b0);

`ifdef TASK14_OUT_CHECKSUM_EN
    q = '{'h0F, 'hF0, 'h33};
    run_packet("csum", q, 0, 3, 1'b0);
    chk("csum:value", (beats_q.size() > 3) ? beats_q[3] : 'hDEAD, 'hCC);
`endif

    // Random bursts, random sink ready
    for (int p = 0; p < 15; p++) begin
      q.delete();
      len = $urandom_range(1, 36);
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, 255));
      run_packet($sformatf("rnd%0d", p), q, 2, (len > DEPTH) ? DEPTH : len, len > DEPTH);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_task_14_out
